// File: rtl/mm_request_scheduler_if.sv
// Bundle of the cache miss port, the memory request/response port and status
// outputs of mm_request_scheduler. clk/reset are kept outside.
interface mm_request_scheduler_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_OPS         = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int OPW = $clog2(NUM_OPS);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  // Handshake: a memory request transfers on every rising edge where
  // mem_req_valid && mem_req_ready; mem_addr/mem_op are held stable while
  // valid is high and ready is low. Miss requests, memory responses and
  // returns are single-cycle strobes without a ready (req_full is the stall).
  logic [ADDR_WIDTH-1:0] mm_req;
  logic [OPW-1:0]        mm_req_op;
  logic                  mm_req_valid;
  logic                  req_full;
  logic [DATA_WIDTH-1:0] mm_ret_data;
  logic [OPW-1:0]        mm_ret_op;
  logic                  mm_ret_valid;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [OPW-1:0]        mem_op;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [DATA_WIDTH-1:0] mem_resp_data;
  logic [OPW-1:0]        mem_resp_op;
  logic                  mem_resp_valid;
  logic [OW-1:0]         outstanding;
  logic                  error;
  logic [1:0]            dbg_state;

  modport slave (
    input  mm_req, mm_req_op, mm_req_valid, mem_req_ready,
           mem_resp_data, mem_resp_op, mem_resp_valid,
    output req_full, mm_ret_data, mm_ret_op, mm_ret_valid,
           mem_addr, mem_op, mem_req_valid, outstanding, error, dbg_state
  );

  modport master (
    output mm_req, mm_req_op, mm_req_valid, mem_req_ready,
           mem_resp_data, mem_resp_op, mem_resp_valid,
    input  req_full, mm_ret_data, mm_ret_op, mm_ret_valid,
           mem_addr, mem_op, mem_req_valid, outstanding, error, dbg_state
  );
endinterface

// File: rtl/mm_request_scheduler.sv
// In-order miss request FIFO feeding main memory with an in-flight cap, plus a
// one-cycle registered forwarder for (possibly out-of-order) memory responses.
module mm_request_scheduler #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_OPS         = 32,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                    clk,
  input logic                    reset,
  mm_request_scheduler_if.slave  bus
);
  localparam int OPW = $clog2(NUM_OPS);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = $clog2(REQ_DEPTH);
  localparam int CW  = $clog2(REQ_DEPTH + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_C = CW'(REQ_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_THROTTLE = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_fifo_addr [REQ_DEPTH];
  logic [OPW-1:0]        r_fifo_op   [REQ_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic [OW-1:0]         r_out;
  logic                  r_error;
  logic                  r_ret_valid;
  logic [DATA_WIDTH-1:0] r_ret_data;
  logic [OPW-1:0]        r_ret_op;

  logic          w_push;
  logic          w_pop;
  logic          w_resp_dec;
  logic          w_err_ovf;
  logic          w_err_spur;
  logic [CW-1:0] w_count_nxt;
  logic [OW-1:0] w_out_nxt;

  // Full is judged on the registered flag, so a pop on the same edge does not
  // rescue an enqueue that the cache was told to stall.
  always_comb begin
    w_push      = bus.mm_req_valid && !r_full;
    w_err_ovf   = bus.mm_req_valid && r_full;
    w_pop       = (r_state == ST_ISSUE) && bus.mem_req_ready;
    w_resp_dec  = bus.mem_resp_valid && (r_out != '0);
    w_err_spur  = bus.mem_resp_valid && (r_out == '0);
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    w_out_nxt   = r_out + OW'(w_pop) - OW'(w_resp_dec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_out       <= '0;
      r_error     <= 1'b0;
      r_ret_valid <= 1'b0;
      r_ret_data  <= '0;
      r_ret_op    <= '0;
      for (int i = 0; i < REQ_DEPTH; i++) begin
        r_fifo_addr[i] <= '0;
        r_fifo_op[i]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_addr[r_wptr] <= bus.mm_req;
        r_fifo_op[r_wptr]   <= bus.mm_req_op;
        r_wptr              <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_out   <= w_out_nxt;
      r_error <= r_error | w_err_ovf | w_err_spur;

      r_ret_valid <= bus.mem_resp_valid;
      if (bus.mem_resp_valid) begin
        r_ret_data <= bus.mem_resp_data;
        r_ret_op   <= bus.mem_resp_op;
      end

      // Next state is chosen from post-edge occupancy and in-flight count so
      // that ISSUE can hold for back-to-back transfers at one per cycle.
      if (w_count_nxt == '0) begin
        r_state <= ST_IDLE;
      end else if (w_out_nxt < MAX_O) begin
        r_state <= ST_ISSUE;
      end else begin
        r_state <= ST_THROTTLE;
      end
    end
  end

  assign bus.mem_req_valid = (r_state == ST_ISSUE);
  assign bus.mem_addr      = r_fifo_addr[r_rptr];
  assign bus.mem_op        = r_fifo_op[r_rptr];
  assign bus.req_full      = r_full;
  assign bus.outstanding   = r_out;
  assign bus.error         = r_error;
  assign bus.mm_ret_valid  = r_ret_valid;
  assign bus.mm_ret_data   = r_ret_data;
  assign bus.mm_ret_op     = r_ret_op;
  assign bus.dbg_state     = r_state;
endmodule
